// File: rtl/keccak_arbiter.sv
// Round-robin job arbiter sharing one keccak sponge core among NUM_REQ requesters.
// Define KECCAK_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module keccak_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [2*NUM_REQ-1:0]    i_req_mode,
  input  logic [64*NUM_REQ-1:0]   i_req_ibytes,
  input  logic [NUM_REQ-1:0]      i_req_ibytes_valid,
  input  logic [11*NUM_REQ-1:0]   i_req_ibytes_len,
  input  logic [10*NUM_REQ-1:0]   i_req_obytes_len,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_req_ibytes_ready,
  output logic [63:0]             o_req_obytes,
  output logic [NUM_REQ-1:0]      o_req_obytes_valid,
  output logic [NUM_REQ-1:0]      o_req_done,
  output logic [1:0]              o_core_mode,
  output logic [63:0]             o_core_ibytes,
  output logic                    o_core_ibytes_valid,
  output logic [10:0]             o_core_ibytes_len,
  output logic [9:0]              o_core_obytes_len,
  input  logic                    i_core_ibytes_ready,
  input  logic [63:0]             i_core_obytes,
  input  logic                    i_core_obytes_valid,
  input  logic                    i_core_obytes_done,
  output logic                    o_busy,
  output logic [IDX_W-1:0]        o_owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       mode_q, mode_d;
  logic [10:0]      ilen_q, ilen_d;
  logic [9:0]       olen_q, olen_d;

  logic [1:0]       mode_a   [NUM_REQ];
  logic [63:0]      ibytes_a [NUM_REQ];
  logic [10:0]      ilen_a   [NUM_REQ];
  logic [9:0]       olen_a   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign mode_a[g]   = i_req_mode[2*g +: 2];
    assign ibytes_a[g] = i_req_ibytes[64*g +: 64];
    assign ilen_a[g]   = i_req_ibytes_len[11*g +: 11];
    assign olen_a[g]   = i_req_obytes_len[10*g +: 10];
  end

  // Explicit compare keeps the wrap correct when NUM_REQ is not a power of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    logic [IDX_W:0] s;
    s = {1'b0, v} + (IDX_W+1)'(1);
    if (s >= NREQ) s = '0;
    return s[IDX_W-1:0];
  endfunction

  // Round-robin search: first requester at or after the pointer.
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && i_req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    ilen_d  = ilen_q;
    olen_d  = olen_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = win;
          mode_d  = mode_a[win];
          ilen_d  = ilen_a[win];
          olen_d  = olen_a[win];
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_RUN;
      S_RUN: begin
        if (i_core_obytes_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
`ifdef KECCAK_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = wrap_inc(owner_q);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      mode_q  <= '0;
      ilen_q  <= '0;
      olen_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      ilen_q  <= ilen_d;
      olen_q  <= olen_d;
    end
  end

  logic [NUM_REQ-1:0] owner_oh;
  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Streaming paths are live only in S_RUN; anything the core emits elsewhere is dropped.
  always_comb begin
    o_busy              = (state_q == S_GRANT) || (state_q == S_RUN);
    o_grant             = o_busy ? owner_oh : '0;
    o_core_ibytes       = '0;
    o_core_ibytes_valid = 1'b0;
    o_req_ibytes_ready  = '0;
    o_req_obytes        = '0;
    o_req_obytes_valid  = '0;
    o_req_done          = '0;
    if (state_q == S_RUN) begin
      o_core_ibytes       = ibytes_a[owner_q];
      o_core_ibytes_valid = i_req_ibytes_valid[owner_q];
      o_req_ibytes_ready  = i_core_ibytes_ready ? owner_oh : '0;
      o_req_obytes        = i_core_obytes;
      o_req_obytes_valid  = i_core_obytes_valid ? owner_oh : '0;
      o_req_done          = i_core_obytes_done ? owner_oh : '0;
    end
  end

  assign o_core_mode       = mode_q;
  assign o_core_ibytes_len = ilen_q;
  assign o_core_obytes_len = olen_q;
  assign o_owner           = owner_q;

endmodule
